// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared opcodes, default widths and controller state encodings
//               for the calculator sequencing block.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int DEF_OPND_W = 32;
    localparam int DEF_RES_W  = 64;

    typedef enum logic [1:0] {
        OPR_ADD = 2'd0,
        OPR_SUB = 2'd1,
        OPR_MUL = 2'd2,
        OPR_DIV = 2'd3
    } calc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } ctrl_state_e;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : calc_controller_if
// Description : Command, calculator-drive and response signals of the
//               calculator controller. master = controller, slave = its peers.
// Revision    : 1.0 - initial release
// ============================================================================
interface calc_controller_if
    import calc_pkg::*;
#(
    parameter int OPND_W = DEF_OPND_W,
    parameter int RES_W  = DEF_RES_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OPND_W-1:0] cmd_a;
    logic [OPND_W-1:0] cmd_b;
    logic [1:0]        cmd_op;
    logic [OPND_W-1:0] calc_a;
    logic [OPND_W-1:0] calc_b;
    logic [1:0]        calc_op;
    logic [RES_W-1:0]  calc_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_result;
    logic              rsp_div_zero;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, calc_result, rsp_ready,
        output cmd_ready, calc_a, calc_b, calc_op, rsp_valid, rsp_result,
               rsp_div_zero, busy
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, calc_result, rsp_ready,
        input  cmd_ready, calc_a, calc_b, calc_op, rsp_valid, rsp_result,
               rsp_div_zero, busy
    );

endinterface : calc_controller_if
`default_nettype wire

// File: rtl/calc_byte_reader.sv
`default_nettype none
// ============================================================================
// Module      : calc_byte_reader
// Description : Byte-wise readout of the held response through a wrapping
//               3-bit pointer advanced by rd_strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_byte_reader
    import calc_pkg::*;
#(
    parameter int RES_W = DEF_RES_W
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              capture,
    input  wire              rsp_valid,
    input  wire              rsp_ready,
    input  wire              rd_strobe,
    input  wire [RES_W-1:0]  rsp_result,
    output logic [7:0]       rd_byte
);

    logic [2:0] r_ptr;

    // A consume wins over a simultaneous strobe so the next response starts at byte 0.
    always_ff @(posedge clk) begin
        if (rst || capture) begin
            r_ptr <= 3'd0;
        end else if (rsp_valid && rsp_ready) begin
            r_ptr <= 3'd0;
        end else if (rsp_valid && rd_strobe) begin
            r_ptr <= r_ptr + 3'd1;
        end
    end

    assign rd_byte = rsp_result[{r_ptr, 3'b000} +: 8];

endmodule : calc_byte_reader
`default_nettype wire

// File: rtl/calc_controller.sv
`default_nettype none
// ============================================================================
// Module      : calc_controller
// Description : Accepts one calculator command, holds operands for
//               EXEC_CYCLES, captures a masked result into a response register.
//               Optional byte readout enabled by CALC_CTRL_BYTE_READ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_controller
    import calc_pkg::*;
#(
    parameter int OPND_W      = DEF_OPND_W,
    parameter int RES_W       = DEF_RES_W,
    parameter int EXEC_CYCLES = 2
) (
    input  wire             clk,
    input  wire             rst,
`ifdef CALC_CTRL_BYTE_READ_EN
    input  wire             rd_strobe,
    output logic [7:0]      rd_byte,
`endif
    calc_controller_if.master bus
);

    localparam logic [3:0] C_CNT_LOAD = 4'(EXEC_CYCLES - 1);

    ctrl_state_e       r_state;
    ctrl_state_e       w_next_state;
    logic              w_accept;
    logic              w_capture;
    logic [3:0]        r_cnt;
    logic [OPND_W-1:0] r_a;
    logic [OPND_W-1:0] r_b;
    logic [1:0]        r_op;
    logic [RES_W-1:0]  r_res;
    logic              r_dz;
    logic [RES_W-1:0]  w_masked;
    logic              w_dz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Bits the calculator does not write for an op are undefined, so only the
    // meaningful slice is kept; add/sub keep the carry/borrow bit.
    always_comb begin
        w_masked = '0;
        w_dz     = 1'b0;
        case (r_op)
            OPR_ADD, OPR_SUB: w_masked[OPND_W:0] = bus.calc_result[OPND_W:0];
            OPR_MUL:          w_masked = bus.calc_result;
            default: begin
                if (r_b == '0) begin
                    w_dz = 1'b1;
                end else begin
                    w_masked[OPND_W-1:0] = bus.calc_result[OPND_W-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= 2'd0;
            r_res <= '0;
            r_dz  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= bus.cmd_a;
                r_b   <= bus.cmd_b;
                r_op  <= bus.cmd_op;
                r_cnt <= C_CNT_LOAD;
            end else if (r_state == ST_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_res <= w_masked;
                r_dz  <= w_dz;
            end
        end
    end

    assign bus.cmd_ready    = (r_state == ST_IDLE);
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.rsp_valid    = (r_state == ST_RESP);
    assign bus.calc_a       = r_a;
    assign bus.calc_b       = r_b;
    assign bus.calc_op      = r_op;
    assign bus.rsp_result   = r_res;
    assign bus.rsp_div_zero = r_dz;

`ifdef CALC_CTRL_BYTE_READ_EN
    calc_byte_reader #(
        .RES_W (RES_W)
    ) u_byte_reader (
        .clk        (clk),
        .rst        (rst),
        .capture    (w_capture),
        .rsp_valid  (bus.rsp_valid),
        .rsp_ready  (bus.rsp_ready),
        .rd_strobe  (rd_strobe),
        .rsp_result (r_res),
        .rd_byte    (rd_byte)
    );
`endif

endmodule : calc_controller
`default_nettype wire

// File: tb/tb_calc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_controller
// Description : Directed self-checking bench for calc_controller with a
//               behavioural calculator that drives garbage in unused bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_controller;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    calc_controller_if #(.OPND_W(32), .RES_W(64)) bus ();

`ifdef CALC_CTRL_BYTE_READ_EN
    logic       rd_strobe;
    logic [7:0] rd_byte;
`endif

    calc_controller #(
        .OPND_W      (32),
        .RES_W       (64),
        .EXEC_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CALC_CTRL_BYTE_READ_EN
        .rd_strobe (rd_strobe),
        .rd_byte   (rd_byte),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Calculator model: upper bits not produced by the op are driven to ones.
    always_comb begin
        case (bus.calc_op)
            2'd0:    bus.calc_result = {31'h7FFF_FFFF, {1'b0, bus.calc_a} + {1'b0, bus.calc_b}};
            2'd1:    bus.calc_result = {31'h7FFF_FFFF, {1'b0, bus.calc_a} - {1'b0, bus.calc_b}};
            2'd2:    bus.calc_result = 64'(bus.calc_a) * 64'(bus.calc_b);
            default: bus.calc_result = (bus.calc_b == 32'd0) ? 64'hDEAD_BEEF_DEAD_BEEF
                                       : {32'hFFFF_FFFF, bus.calc_a / bus.calc_b};
        endcase
    end

    // Drives one command, returns edges from acceptance until rsp_valid (bounded).
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, output int lat);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.rsp_result !== 64'd0) begin bad++; $display("FAIL reset_rsp_result got=%h exp=0", bus.rsp_result); end
        total++; if (bus.calc_a !== 32'd0 || bus.calc_op !== 2'd0) begin bad++; $display("FAIL reset_calc got a=%h op=%0d exp 0", bus.calc_a, bus.calc_op); end
    endtask

    task automatic test_add();
        int lat;
        send_cmd(32'hFFFF_FFFF, 32'd1, 2'd0, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", lat); end
        total++; if (bus.rsp_result !== 64'h1_0000_0000) begin bad++; $display("FAIL add_result got=%h exp=100000000", bus.rsp_result); end
        total++; if (bus.rsp_div_zero !== 1'b0) begin bad++; $display("FAIL add_div_zero got=%b exp=0", bus.rsp_div_zero); end
        consume();
        total++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL add_consume got valid=%b ready=%b exp 0/1", bus.rsp_valid, bus.cmd_ready); end
    endtask

    task automatic test_sub();
        int lat;
        send_cmd(32'd1, 32'd2, 2'd1, lat);
        total++; if (bus.rsp_result !== 64'h1_FFFF_FFFF) begin bad++; $display("FAIL sub_result got=%h exp=1ffffffff", bus.rsp_result); end
        consume();
    endtask

    task automatic test_mul();
        int lat;
        send_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, lat);
        total++; if (bus.rsp_result !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL mul_result got=%h exp=fffffffe00000001", bus.rsp_result); end
        consume();
    endtask

    task automatic test_div();
        int lat;
        send_cmd(32'd100, 32'd0, 2'd3, lat);
        total++; if (bus.rsp_result !== 64'd0) begin bad++; $display("FAIL div0_result got=%h exp=0", bus.rsp_result); end
        total++; if (bus.rsp_div_zero !== 1'b1) begin bad++; $display("FAIL div0_flag got=%b exp=1", bus.rsp_div_zero); end
        consume();
        send_cmd(32'd100, 32'd7, 2'd3, lat);
        total++; if (bus.rsp_result !== 64'd14) begin bad++; $display("FAIL div7_result got=%h exp=e", bus.rsp_result); end
        total++; if (bus.rsp_div_zero !== 1'b0) begin bad++; $display("FAIL div7_flag got=%b exp=0", bus.rsp_div_zero); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        send_cmd(32'd3, 32'd4, 2'd0, lat);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 32'd10;
        bus.cmd_b     = 32'd20;
        bus.cmd_op    = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (bus.cmd_ready !== 1'b0 || bus.rsp_result !== 64'd7 || bus.rsp_valid !== 1'b1) begin
                bad++; $display("FAIL hold_cycle%0d got ready=%b valid=%b res=%h exp 0/1/7", i, bus.cmd_ready, bus.rsp_valid, bus.rsp_result);
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        total++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got ready=%b valid=%b exp 1/0", bus.cmd_ready, bus.rsp_valid); end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        total++; if (bus.busy !== 1'b1 || bus.calc_a !== 32'd10) begin bad++; $display("FAIL b2b_accept got busy=%b a=%h exp 1/a", bus.busy, bus.calc_a); end
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        total++; if (bus.rsp_result !== 64'd30) begin bad++; $display("FAIL b2b_result got=%h exp=1e", bus.rsp_result); end
        consume();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 32'h1234;
        bus.cmd_b     = 32'h5;
        bus.cmd_op    = 2'd2;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_state got busy=%b valid=%b ready=%b exp 0/0/1", bus.busy, bus.rsp_valid, bus.cmd_ready);
        end
        total++; if (bus.calc_a !== 32'd0 || bus.calc_b !== 32'd0 || bus.calc_op !== 2'd0) begin
            bad++; $display("FAIL rstmid_calc got a=%h b=%h op=%0d exp 0", bus.calc_a, bus.calc_b, bus.calc_op);
        end
    endtask

`ifdef CALC_CTRL_BYTE_READ_EN
    task automatic test_byte_read();
        int lat;
        logic [7:0] exp_b [8];
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(32'h0403_0201, 32'd1, 2'd2, lat);
        for (int i = 0; i < 9; i++) begin
            total++; if (rd_byte !== exp_b[i % 8]) begin bad++; $display("FAIL byte_read%0d got=%h exp=%h", i, rd_byte, exp_b[i % 8]); end
            @(negedge clk);
            rd_strobe = 1'b1;
            @(posedge clk);
            #1;
            rd_strobe = 1'b0;
        end
        @(negedge clk);
        rd_strobe     = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_strobe     = 1'b0;
        bus.rsp_ready = 1'b0;
        total++; if (rd_byte !== 8'h01) begin bad++; $display("FAIL byte_consume_ptr got=%h exp=01", rd_byte); end
    endtask
`endif

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = 2'd0;
        bus.rsp_ready = 1'b0;
`ifdef CALC_CTRL_BYTE_READ_EN
        rd_strobe     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid();
`ifdef CALC_CTRL_BYTE_READ_EN
        test_byte_read();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_calc_controller
`default_nettype wire
